// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage data-memory controller: word/byte loads and stores plus two-access LDI/STI.
// Optional macro MEM_UNALIGNED_TRAP_EN: odd word addresses skip memory and pulse misaligned.
module mem_access_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_address,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [1:0]       mem_byte_enable,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_resp,
  output logic [WIDTH-1:0] rdata_out,
  output logic             rdata_valid,
  output logic             misaligned,
  output logic [2:0]       dbg_state
);

  // Handshake: a request is offered by req_valid with a non-NONE op; the unit holds the
  // pipeline with stall until DONE, and upstream keeps req_* stable while stall is high.

`ifdef MEM_UNALIGNED_TRAP_EN
  localparam logic TrapEn = 1'b1;
`else
  localparam logic TrapEn = 1'b0;
`endif

  localparam logic [2:0] OP_LDR = 3'd1;
  localparam logic [2:0] OP_LDB = 3'd2;
  localparam logic [2:0] OP_STB = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_STI = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IND_RD  = 3'd1,
    S_IND_GAP = 3'd2,
    S_ACCESS  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  function automatic logic op_active(input logic [2:0] op);
    return (op != 3'd0) && (op != 3'd7);
  endfunction

  function automatic logic op_is_load(input logic [2:0] op);
    return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI);
  endfunction

  function automatic logic op_is_byte(input logic [2:0] op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

  function automatic logic op_is_ind(input logic [2:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic [WIDTH-1:0] mem_address_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [1:0]       mem_be_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rdata_valid_q;
  logic             misaligned_q;

  // The final access is launched either from IDLE (direct op) or from IND_GAP (pointer in addr_q).
  logic [2:0]       src_op;
  logic [WIDTH-1:0] src_addr;
  logic [WIDTH-1:0] src_wdata;
  logic             src_skip;
  logic             launch_read;
  logic             launch_write;
  logic [WIDTH-1:0] launch_addr;
  logic [WIDTH-1:0] launch_wdata;
  logic [1:0]       launch_be;
  logic             acc_skip;
  logic [7:0]       byte_sel;
  logic [WIDTH-1:0] load_result;

  always_comb begin
    src_op    = req_op;
    src_addr  = req_address;
    src_wdata = req_wdata;
    if (state_q == S_IND_GAP) begin
      src_op    = op_q;
      src_addr  = addr_q;
      src_wdata = wdata_q;
    end
    src_skip     = TrapEn & ~op_is_byte(src_op) & src_addr[0];
    launch_read  = op_is_load(src_op) & ~src_skip;
    launch_write = ~op_is_load(src_op) & ~src_skip;
    launch_addr  = {src_addr[WIDTH-1:1], 1'b0};
    launch_be    = 2'b11;
    launch_wdata = src_wdata;
    if (op_is_byte(src_op)) begin
      launch_be    = src_addr[0] ? 2'b10 : 2'b01;
      launch_wdata = {src_wdata[7:0], src_wdata[7:0]};
    end
  end

  always_comb begin
    acc_skip    = TrapEn & ~op_is_byte(op_q) & addr_q[0];
    byte_sel    = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    load_result = mem_rdata;
    if (op_q == OP_LDB) begin
      load_result = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      op_q          <= 3'd0;
      addr_q        <= '0;
      wdata_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= 2'b00;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && op_active(req_op)) begin
            op_q    <= req_op;
            addr_q  <= req_address;
            wdata_q <= req_wdata;
            if (op_is_ind(req_op)) begin
              state_q       <= S_IND_RD;
              mem_read_q    <= 1'b1;
              mem_address_q <= {req_address[WIDTH-1:1], 1'b0};
              mem_be_q      <= 2'b11;
            end else begin
              state_q       <= S_ACCESS;
              mem_read_q    <= launch_read;
              mem_write_q   <= launch_write;
              mem_address_q <= launch_addr;
              mem_wdata_q   <= launch_wdata;
              mem_be_q      <= launch_be;
            end
          end
        end
        S_IND_RD: begin
          if (mem_resp) begin
            addr_q     <= mem_rdata;
            mem_read_q <= 1'b0;
            state_q    <= S_IND_GAP;
          end
        end
        S_IND_GAP: begin
          state_q       <= S_ACCESS;
          mem_read_q    <= launch_read;
          mem_write_q   <= launch_write;
          mem_address_q <= launch_addr;
          mem_wdata_q   <= launch_wdata;
          mem_be_q      <= launch_be;
        end
        S_ACCESS: begin
          if (acc_skip) begin
            state_q      <= S_DONE;
            misaligned_q <= 1'b1;
          end else if (mem_resp) begin
            state_q     <= S_DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (op_is_load(op_q)) begin
              rdata_q       <= load_result;
              rdata_valid_q <= 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall           = req_valid & op_active(req_op) & (state_q != S_DONE);
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign rdata_out       = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign misaligned      = misaligned_q & TrapEn;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan scenarios plus a random back-to-back run.
module tb_mem_access_unit;

  localparam logic [2:0] LDR = 3'd1, LDB = 3'd2, STR = 3'd3, STB = 3'd4, LDI = 3'd5, STI = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] req_address = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_resp = 1'b0;
  logic        stall, mem_read, mem_write, rdata_valid, misaligned;
  logic [15:0] mem_address, mem_wdata, rdata_out;
  logic [1:0]  mem_byte_enable;
  logic [2:0]  dbg_state;

  mem_access_unit #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_address(req_address), .req_wdata(req_wdata), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .misaligned(misaligned), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
  } acc_t;

  logic [15:0] exp_q[$];
  acc_t        exp_acc_q[$];
  logic [15:0] rd_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          wait_cfg = 0;
  int          waited = 0;
  int          valid_pulses = 0;
  int          mis_pulses = 0;
  logic        strb_tr[0:63];
  int          stall_cnt;
  int          done_idx;
  logic [15:0] last_load;

  // Memory responder: honours wait_cfg, checks each completed access against exp_acc_q.
  always @(negedge clk) begin
    acc_t e;
    if (!reset_n) begin
      mem_resp = 1'b0;
      waited = 0;
    end else begin
      mem_resp = 1'b0;
      if (mem_read || mem_write) begin
        if (waited >= wait_cfg) begin
          waited = 0;
          mem_resp = 1'b1;
          mem_rdata = 16'h0;
          if (mem_read && rd_q.size() > 0) mem_rdata = rd_q.pop_front();
          vectors++;
          if (exp_acc_q.size() == 0) begin
            miscompares++;
            $display("FAIL access: unexpected rd=%0b wr=%0b addr=%h", mem_read, mem_write, mem_address);
          end else begin
            e = exp_acc_q.pop_front();
            if (mem_write !== e.wr || mem_read !== !e.wr || mem_address !== e.addr ||
                mem_byte_enable !== e.be || (e.wr && mem_wdata !== e.wd)) begin
              miscompares++;
              $display("FAIL access: got wr=%0b addr=%h be=%b wd=%h, expected wr=%0b addr=%h be=%b wd=%h",
                       mem_write, mem_address, mem_byte_enable, mem_wdata, e.wr, e.addr, e.be, e.wd);
            end
          end
        end else begin
          waited++;
        end
      end
    end
  end

  // Load-result monitor: pops the expected queue on each rdata_valid pulse.
  always @(negedge clk) begin
    logic [15:0] x;
    if (reset_n && misaligned) mis_pulses++;
    if (reset_n && rdata_valid) begin
      valid_pulses++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rdata: unexpected pulse with rdata_out=%h", rdata_out);
      end else begin
        x = exp_q.pop_front();
        if (rdata_out !== x) begin
          miscompares++;
          $display("FAIL rdata: got %h expected %h", rdata_out, x);
        end
      end
    end
  end

  // ---------------- driver / model ----------------
  task automatic run_op(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd,
                        input int waits);
    @(negedge clk);
    wait_cfg = waits;
    req_valid = 1'b1; req_op = op; req_address = addr; req_wdata = wd;
    for (int i = 0; i < 64; i++) strb_tr[i] = 1'b0;
    stall_cnt = 0;
    done_idx = -1;
    for (int i = 0; i < 64; i++) begin
      #1;
      strb_tr[i] = mem_read | mem_write;
      if (!stall) begin
        done_idx = i;
        break;
      end
      stall_cnt++;
      @(negedge clk);
    end
    if (done_idx < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: op=%0d addr=%h never left stall", op, addr);
    end
    req_valid = 1'b0;
    req_op = 3'd0;
  endtask

  // Reference behaviour of one operation; ptr is the pointer memory returns, rv the final read data.
  task automatic model_push(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd,
                            input logic [15:0] ptr, input logic [15:0] rv);
    logic [15:0] fa;
    logic [7:0]  b;
    fa = addr;
    if (op == LDI || op == STI) begin
      exp_acc_q.push_back('{wr: 1'b0, addr: {addr[15:1], 1'b0}, be: 2'b11, wd: 16'h0});
      rd_q.push_back(ptr);
      fa = ptr;
    end
    case (op)
      LDR, LDI: begin
        exp_acc_q.push_back('{wr: 1'b0, addr: {fa[15:1], 1'b0}, be: 2'b11, wd: 16'h0});
        rd_q.push_back(rv);
        exp_q.push_back(rv);
        last_load = rv;
      end
      LDB: begin
        exp_acc_q.push_back('{wr: 1'b0, addr: {fa[15:1], 1'b0}, be: fa[0] ? 2'b10 : 2'b01, wd: 16'h0});
        rd_q.push_back(rv);
        b = fa[0] ? rv[15:8] : rv[7:0];
        exp_q.push_back({{8{b[7]}}, b});
        last_load = {{8{b[7]}}, b};
      end
      STR, STI: exp_acc_q.push_back('{wr: 1'b1, addr: {fa[15:1], 1'b0}, be: 2'b11, wd: wd});
      default:  exp_acc_q.push_back('{wr: 1'b1, addr: {fa[15:1], 1'b0}, be: fa[0] ? 2'b10 : 2'b01,
                                      wd: {wd[7:0], wd[7:0]}});
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, rdata_out, rdata_valid,
         misaligned, stall} !== '0 || dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state: rd=%0b wr=%0b addr=%h wd=%h be=%b rdata=%h state=%0d",
               mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, rdata_out, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_ldr_wait;
    int p0;
    p0 = valid_pulses;
    model_push(LDR, 16'h3001, 16'h0, 16'h0, 16'hBEEF);
    run_op(LDR, 16'h3001, 16'h0, 2);
    vectors++;
    if (stall_cnt !== 4 || done_idx !== 4) begin
      miscompares++;
      $display("FAIL ldr_stall: stall=%0d done=%0d expected 4/4", stall_cnt, done_idx);
    end
    vectors++;
    if (rdata_out !== 16'hBEEF || valid_pulses - p0 !== 1) begin
      miscompares++;
      $display("FAIL ldr_result: rdata=%h pulses=%0d expected BEEF/1", rdata_out, valid_pulses - p0);
    end
  endtask

  task automatic test_stb;
    int p0;
    p0 = valid_pulses;
    exp_acc_q.push_back('{wr: 1'b1, addr: 16'h4000, be: 2'b10, wd: 16'hA5A5});
    run_op(STB, 16'h4001, 16'h12A5, 0);
    vectors++;
    if (stall_cnt !== 2 || done_idx !== 2 || strb_tr[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL stb_timing: stall=%0d done=%0d expected 2/2", stall_cnt, done_idx);
    end
    vectors++;
    if (valid_pulses - p0 !== 0 || rdata_out !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL stb_no_load: pulses=%0d rdata=%h expected 0/BEEF", valid_pulses - p0, rdata_out);
    end
  endtask

  task automatic test_ldb;
    model_push(LDB, 16'h5000, 16'h0, 16'h0, 16'h7F80);
    run_op(LDB, 16'h5000, 16'h0, 0);
    vectors++;
    if (rdata_out !== 16'hFF80) begin
      miscompares++;
      $display("FAIL ldb_low: got %h expected FF80", rdata_out);
    end
    model_push(LDB, 16'h5001, 16'h0, 16'h0, 16'h7F80);
    run_op(LDB, 16'h5001, 16'h0, 1);
    vectors++;
    if (rdata_out !== 16'h007F) begin
      miscompares++;
      $display("FAIL ldb_high: got %h expected 007F", rdata_out);
    end
  endtask

  task automatic test_ldi;
    model_push(LDI, 16'h6000, 16'h0, 16'h7000, 16'h1234);
    run_op(LDI, 16'h6000, 16'h0, 0);
    vectors++;
    if (done_idx !== 4 || strb_tr[1] !== 1'b1 || strb_tr[2] !== 1'b0 || strb_tr[3] !== 1'b1 ||
        strb_tr[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL ldi_timing: done=%0d strobes=%0b%0b%0b%0b expected 4 / 1010",
               done_idx, strb_tr[1], strb_tr[2], strb_tr[3], strb_tr[4]);
    end
    vectors++;
    if (rdata_out !== 16'h1234) begin
      miscompares++;
      $display("FAIL ldi_result: got %h expected 1234", rdata_out);
    end
  endtask

  task automatic test_sti;
    model_push(STI, 16'h6101, 16'h5A5A, 16'h0800, 16'h0);
    run_op(STI, 16'h6101, 16'h5A5A, 1);
    vectors++;
    if (done_idx !== 6) begin
      miscompares++;
      $display("FAIL sti_timing: done=%0d expected 6", done_idx);
    end
  endtask

  task automatic test_unaligned_word;
    int m0;
    m0 = mis_pulses;
`ifdef MEM_UNALIGNED_TRAP_EN
    run_op(STR, 16'h2003, 16'hCAFE, 0);
    vectors++;
    if (stall_cnt !== 2 || mis_pulses - m0 !== 1) begin
      miscompares++;
      $display("FAIL trap_str: stall=%0d mis=%0d expected 2/1", stall_cnt, mis_pulses - m0);
    end
`else
    exp_acc_q.push_back('{wr: 1'b1, addr: 16'h2002, be: 2'b11, wd: 16'hCAFE});
    run_op(STR, 16'h2003, 16'hCAFE, 0);
    vectors++;
    if (stall_cnt !== 2 || mis_pulses - m0 !== 0) begin
      miscompares++;
      $display("FAIL str_odd: stall=%0d mis=%0d expected 2/0", stall_cnt, mis_pulses - m0);
    end
`endif
  endtask

  task automatic test_reset_mid;
    wait_cfg = 20;
    @(negedge clk);
    req_valid = 1'b1; req_op = LDR; req_address = 16'h1234;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (mem_read !== 1'b1 || dbg_state !== 3'd3) begin
      miscompares++;
      $display("FAIL mid_access: rd=%0b state=%0d expected 1/3", mem_read, dbg_state);
    end
    reset_n = 1'b0;
    req_valid = 1'b0; req_op = 3'd0;
    #1;
    vectors++;
    if ({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, rdata_out, rdata_valid,
         misaligned, stall} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: rd=%0b wr=%0b addr=%h be=%b rdata=%h", mem_read, mem_write,
               mem_address, mem_byte_enable, rdata_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_acc_q.delete(); rd_q.delete(); exp_q.delete();
    last_load = 16'h0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_address = 16'h4444;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL none_stall: got %0b expected 0", stall);
    end
    req_op = 3'd7;
    @(negedge clk);
    #1;
    vectors++;
    if (stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL none_idle: stall=%0b rd=%0b wr=%0b state=%0d expected 0/0/0/0",
               stall, mem_read, mem_write, dbg_state);
    end
    req_valid = 1'b0; req_op = 3'd0;
  endtask

  task automatic test_back_to_back;
    logic [2:0]  op;
    logic [15:0] addr, wd, ptr, rv;
    int          w;
    for (int n = 0; n < 24; n++) begin
      op   = 3'($urandom_range(1, 6));
      addr = 16'($urandom_range(0, 16'hFFFF));
      wd   = 16'($urandom_range(0, 16'hFFFF));
      ptr  = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      rv   = 16'($urandom_range(0, 16'hFFFF));
      w    = $urandom_range(0, 2);
      if (op != LDB && op != STB) addr[0] = 1'b0;
      model_push(op, addr, wd, ptr, rv);
      run_op(op, addr, wd, w);
      vectors++;
      if (rdata_out !== last_load || strb_tr[done_idx] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b[%0d]: op=%0d rdata=%h expected %h, done strobe=%0b",
                 n, op, rdata_out, last_load, strb_tr[done_idx]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    last_load = 16'h0;
    test_reset;
    test_ldr_wait;
    test_stb;
    test_ldb;
    test_ldi;
    test_sti;
    test_unaligned_word;
    test_reset_mid;
    test_back_to_back;
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || exp_acc_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d loads and %0d accesses still expected", exp_q.size(), exp_acc_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
